// File: rtl/shift_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : shift_pkg                                                   |
// | Purpose  : Shared types and constants for the iterative shifter:       |
// |            operation codes, FSM state encoding and datapath width.     |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
package shift_pkg;

    localparam int DATA_W = 32;

    // Operation codes as presented on the op port (low 3 bits).
    typedef enum logic [2:0] {
        NOP = 3'd0,
        SLL = 3'd1,
        SRL = 3'd2,
        SRA = 3'd3,
        ROL = 3'd4,
        ROR = 3'd5
    } shift_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_state_t;

endpackage : shift_pkg
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : shift_step                                                  |
// | Purpose  : Combinational single-bit shift/rotate step.                 |
// | Ports    : op       in  shift_op_t  decoded operation                   |
// |            din      in  32          value before the step               |
// |            dout     out 32          value after one single-bit step     |
// |            is_shift out 1           op performs work in this build      |
// | Config   : SHIFT_ROTATE_EN - when defined, ROL/ROR are implemented;    |
// |            otherwise they behave as NOP and no rotate logic exists.    |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module shift_step
    import shift_pkg::*;
(
    input  shift_op_t         op,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              is_shift
);

    always_comb begin
        dout     = din;
        is_shift = 1'b0;
        case (op)
            SLL: begin
                dout     = {din[DATA_W-2:0], 1'b0};
                is_shift = 1'b1;
            end
            SRL: begin
                dout     = {1'b0, din[DATA_W-1:1]};
                is_shift = 1'b1;
            end
            SRA: begin
                dout     = {din[DATA_W-1], din[DATA_W-1:1]};
                is_shift = 1'b1;
            end
`ifdef SHIFT_ROTATE_EN
            ROL: begin
                dout     = {din[DATA_W-2:0], din[DATA_W-1]};
                is_shift = 1'b1;
            end
            ROR: begin
                dout     = {din[0], din[DATA_W-1:1]};
                is_shift = 1'b1;
            end
`endif
            default: begin
                dout     = din;
                is_shift = 1'b0;
            end
        endcase
    end

endmodule : shift_step
`default_nettype wire

// File: rtl/shift_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : shift_unit                                                  |
// | Purpose  : Iterative multicycle shifter, one bit per clock, with a     |
// |            start/done handshake and a registered, held result.         |
// | Ports    : clk     in  1     system clock, rising edge                  |
// |            rst_n   in  1     synchronous reset, active low              |
// |            start   in  1     request, sampled only in IDLE              |
// |            op      in  OP_W  0 NOP,1 SLL,2 SRL,3 SRA,4 ROL,5 ROR        |
// |            shamt   in  5     shift count 0..31                          |
// |            operand in  32    value to shift                             |
// |            result  out 32    shifted value, registered                  |
// |            busy    out 1     high from cycle after accept until done    |
// |            done    out 1     single-cycle completion pulse              |
// | Config   : SHIFT_ROTATE_EN - enables ROL/ROR (see shift_step).          |
// | Note     : OP_W must be at least 3.                                     |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module shift_unit
    import shift_pkg::*;
#(
    parameter int OP_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [OP_W-1:0]   op,
    input  logic [4:0]        shamt,
    input  logic [DATA_W-1:0] operand,
    output logic [DATA_W-1:0] result,
    output logic              busy,
    output logic              done
);

    shift_state_t      r_state;
    shift_op_t         r_op;
    logic [4:0]        r_cnt;
    logic [DATA_W-1:0] r_result;
    logic              r_busy;
    logic              r_done;

    shift_op_t         w_op_dec;
    shift_op_t         w_step_op;
    logic [DATA_W-1:0] w_step;
    logic              w_is_shift;

    // Any code above ROR, including wide codes, collapses to NOP.
    always_comb begin
        w_op_dec = NOP;
        if (op <= OP_W'(3'd5)) begin
            w_op_dec = shift_op_t'(op[2:0]);
        end
    end

    // In IDLE the step unit only classifies the incoming op; while shifting
    // it works on the latched op so later changes on op are ignored.
    assign w_step_op = (r_state == IDLE) ? w_op_dec : r_op;

    shift_step u_step (
        .op       (w_step_op),
        .din      (r_result),
        .dout     (w_step),
        .is_shift (w_is_shift)
    );

    // busy/done are registered alongside the state transition so they are
    // glitch-free and line up exactly with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_op     <= NOP;
            r_cnt    <= 5'd0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                    if (start) begin
                        r_result <= operand;
                        r_cnt    <= shamt;
                        r_op     <= w_op_dec;
                        r_busy   <= 1'b1;
                        if ((shamt != 5'd0) && w_is_shift) begin
                            r_state <= SHIFT;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    r_result <= w_step;
                    r_cnt    <= r_cnt - 5'd1;
                    if (r_cnt == 5'd1) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign result = r_result;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule : shift_unit
`default_nettype wire
